// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder buffer: geometry, entry kinds and the entry record
// used by the ROB, reservation stations and register file.
package rob_commit_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int CNT_W     = 5;
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    KIND_SIMPLE = 2'd0,
    KIND_NORMAL = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_STORE  = 2'd3
  } rob_kind_e;

  typedef struct packed {
    logic      busy;
    logic      ready;
    rob_kind_e kind;
    reg_t      rd;
    word_t     value;
    logic      mispredict;
  } rob_entry_t;

  // A branch-or-store marked simple is a store: it has nothing left to wait for
  // in the ROB and the store buffer holds it until release. Branches wait for the CDB.
  function automatic rob_kind_e decode_kind(input logic is_simple, input logic is_branch_or_store);
    if (is_branch_or_store) return is_simple ? KIND_STORE : KIND_BRANCH;
    return is_simple ? KIND_SIMPLE : KIND_NORMAL;
  endfunction

  function automatic logic writes_rd(input rob_kind_e kind);
    return (kind == KIND_SIMPLE) || (kind == KIND_NORMAL);
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, CDB and commit signals of the reorder buffer. The master drives
// allocation and CDB broadcasts; the slave (the ROB) returns tags and commit pulses.
interface rob_commit_if;
  import rob_commit_pkg::*;

  logic  alloc_valid;
  logic  alloc_is_simple;
  word_t alloc_simple_value;
  logic  alloc_is_branch_or_store;
  reg_t  alloc_rd;
  logic  alloc_ready;
  tag_t  alloc_tag;

  logic  cdb_valid;
  tag_t  cdb_tag;
  word_t cdb_value;
  logic  cdb_mispredict;

  logic  register_update_flag;
  reg_t  register_commit_dest;
  word_t register_commit_value;
  tag_t  rename_of_commit_ins;
  logic  register_flush;
  logic  store_commit;
  tag_t  store_commit_tag;

  modport master (
    output alloc_valid, alloc_is_simple, alloc_simple_value, alloc_is_branch_or_store, alloc_rd,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    input  alloc_ready, alloc_tag,
    input  register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins,
    input  register_flush, store_commit, store_commit_tag
  );

  modport slave (
    input  alloc_valid, alloc_is_simple, alloc_simple_value, alloc_is_branch_or_store, alloc_rd,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    output alloc_ready, alloc_tag,
    output register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins,
    output register_flush, store_commit, store_commit_tag
  );

endinterface

// File: rtl/rob_commit.sv
// 16-entry reorder buffer: in-order allocation, out-of-order completion via the CDB,
// in-order commit of at most one entry per cycle with registered commit pulses.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  rob_commit_if.slave  bus
);

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];
  tag_t       head_q, head_d;
  tag_t       tail_q, tail_d;
  cnt_t       count_q, count_d;

  logic       upd_q, upd_d;
  logic       flush_q, flush_d;
  logic       store_q, store_d;
  reg_t       dest_q, dest_d;
  word_t      value_q, value_d;
  tag_t       rename_q, rename_d;
  tag_t       store_tag_q, store_tag_d;

  rob_entry_t head_entry;
  logic       rob_full;
  logic       commit_fire;
  logic       flush_fire;
  logic       alloc_fire;
  logic       cdb_fire;

  assign head_entry = entries_q[head_q];
  assign rob_full   = (count_q == cnt_t'(ROB_DEPTH));

  // alloc_ready looks at count only, so a commit in the same cycle never frees a
  // slot early for an allocation into a full buffer.
  assign bus.alloc_ready = !rob_full;
  assign bus.alloc_tag   = tail_q;

  assign commit_fire = rdy && (count_q != '0) && head_entry.busy && head_entry.ready;
  assign flush_fire  = commit_fire && (head_entry.kind == KIND_BRANCH) && head_entry.mispredict;
  assign alloc_fire  = rdy && bus.alloc_valid && !rob_full && !flush_fire;
  assign cdb_fire    = rdy && bus.cdb_valid && entries_q[bus.cdb_tag].busy && !flush_fire;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_d       = 1'b0;
    flush_d     = 1'b0;
    store_d     = 1'b0;
    dest_d      = dest_q;
    value_d     = value_q;
    rename_d    = rename_q;
    store_tag_d = store_tag_q;

    if (cdb_fire) begin
      entries_d[bus.cdb_tag].ready      = 1'b1;
      entries_d[bus.cdb_tag].value      = bus.cdb_value;
      entries_d[bus.cdb_tag].mispredict = bus.cdb_mispredict;
    end

    // The tail slot is never busy while the buffer has room, so it cannot collide
    // with a CDB write in the same cycle.
    if (alloc_fire) begin
      entries_d[tail_q].busy       = 1'b1;
      entries_d[tail_q].ready      = bus.alloc_is_simple;
      entries_d[tail_q].kind       = decode_kind(bus.alloc_is_simple, bus.alloc_is_branch_or_store);
      entries_d[tail_q].rd         = bus.alloc_rd;
      entries_d[tail_q].value      = bus.alloc_is_simple ? bus.alloc_simple_value : '0;
      entries_d[tail_q].mispredict = 1'b0;
      tail_d                       = tail_q + tag_t'(1);
    end

    if (commit_fire) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = head_q + tag_t'(1);
      if (writes_rd(head_entry.kind)) begin
        upd_d    = 1'b1;
        dest_d   = head_entry.rd;
        value_d  = head_entry.value;
        rename_d = head_q;
      end
      if (head_entry.kind == KIND_STORE) begin
        store_d     = 1'b1;
        store_tag_d = head_q;
      end
    end

    unique case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // A mispredicted branch discards everything younger; alloc and CDB were
    // already suppressed above, so only the pointers and flags need clearing.
    if (flush_fire) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].busy       = 1'b0;
        entries_d[i].ready      = 1'b0;
        entries_d[i].mispredict = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry array is flop-based and its busy bits gate commit, so it is
      // cleared on reset rather than treated as an unreset RAM.
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_q       <= 1'b0;
      flush_q     <= 1'b0;
      store_q     <= 1'b0;
      dest_q      <= '0;
      value_q     <= '0;
      rename_q    <= '0;
      store_tag_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples the
      // pre-edge values computed by the combinational block.
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_q       <= upd_d;
      flush_q     <= flush_d;
      store_q     <= store_d;
      dest_q      <= dest_d;
      value_q     <= value_d;
      rename_q    <= rename_d;
      store_tag_q <= store_tag_d;
    end
  end

  assign bus.register_update_flag  = upd_q;
  assign bus.register_commit_dest  = dest_q;
  assign bus.register_commit_value = value_q;
  assign bus.rename_of_commit_ins  = rename_q;
  assign bus.register_flush        = flush_q;
  assign bus.store_commit          = store_q;
  assign bus.store_commit_tag      = store_tag_q;

endmodule
